// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle controller.
//   Opcode values, FSM state enum, decoder class enum, ALU-op codes and
//   write-back mux encodings. No ports.
package ctrl_pkg;

  localparam logic [3:0] OpLdi   = 4'd0;
  localparam logic [3:0] OpAdd   = 4'd1;
  localparam logic [3:0] OpSub   = 4'd2;
  localparam logic [3:0] OpLoad  = 4'd3;
  localparam logic [3:0] OpStore = 4'd4;
  localparam logic [3:0] OpJmp   = 4'd5;
  localparam logic [3:0] OpJz    = 4'd6;
  localparam logic [3:0] OpHalt  = 4'd15;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt,
    StTrap
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsMem,
    ClsBranch,
    ClsHalt,
    ClsIllegal
  } op_class_e;

  localparam logic [1:0] AluPass = 2'd0;
  localparam logic [1:0] AluAdd  = 2'd1;
  localparam logic [1:0] AluSub  = 2'd2;

  localparam logic WbAlu = 1'b0;
  localparam logic WbMem = 1'b1;

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational opcode decoder.
//   i_opcode   4-bit opcode from the instruction register
//   o_cls      instruction class (op_class_e encoding)
//   o_alu_op   ALU operation select
//   o_dmem_we  1 for stores, 0 otherwise
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic [2:0] o_cls,
  output logic [1:0] o_alu_op,
  output logic       o_dmem_we
);

  always_comb begin
    o_cls     = ClsIllegal;
    o_alu_op  = AluPass;
    o_dmem_we = 1'b0;
    case (i_opcode)
      OpLdi: begin
        o_cls    = ClsAlu;
        o_alu_op = AluPass;
      end
      OpAdd: begin
        o_cls    = ClsAlu;
        o_alu_op = AluAdd;
      end
      OpSub: begin
        o_cls    = ClsAlu;
        o_alu_op = AluSub;
      end
      OpLoad:       o_cls = ClsMem;
      OpStore: begin
        o_cls     = ClsMem;
        o_dmem_we = 1'b1;
      end
      OpJmp, OpJz:  o_cls = ClsBranch;
      OpHalt:       o_cls = ClsHalt;
      default:      o_cls = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute controller for the 8-bit core.
//   Owns PC, IR and the FSM; drives the register file, ALU select, write-back
//   mux and the req/ack instruction and data memory interfaces.
//   clk/reset_n                   clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata       instruction fetch handshake
//   dmem_req/we/addr/ack          data access handshake
//   rf_raddr_a/b, rf_rdata_a      register file reads (rd, rs)
//   rf_we/rf_waddr                register file write strobe/address
//   wb_sel, alu_op, imm           datapath selects and immediate
//   halted                        core stopped
//   epc                           trapping PC (only with MULTICYCLE_CTRL_TRAP_EN)
// Build option: define MULTICYCLE_CTRL_TRAP_EN to trap illegal opcodes to
// TRAP_VEC and expose epc; otherwise illegal opcodes are NOPs.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned       INSTR_W  = 16,
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(8'hF0)
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  input  logic               dmem_ack,
  output logic [3:0]         rf_raddr_a,
  output logic [3:0]         rf_raddr_b,
  input  logic [DATA_W-1:0]  rf_rdata_a,
  output logic               rf_we,
  output logic [3:0]         rf_waddr,
  output logic               wb_sel,
  output logic [1:0]         alu_op,
  output logic [DATA_W-1:0]  imm,
  output logic               halted
`ifdef MULTICYCLE_CTRL_TRAP_EN
  ,
  output logic [ADDR_W-1:0]  epc
`endif
);

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic [INSTR_W-1:0]  r_ir, w_ir_nxt;
`ifdef MULTICYCLE_CTRL_TRAP_EN
  logic [ADDR_W-1:0]   r_epc, w_epc_nxt;
`endif

  logic [3:0]          w_opcode, w_rd, w_rs;
  logic [ADDR_W-1:0]   w_addr;
  logic [2:0]          w_cls_raw;
  op_class_e           w_cls;
  logic [1:0]          w_alu_op;
  logic                w_dec_we;

  assign w_opcode = r_ir[INSTR_W-1 -: 4];
  assign w_rd     = r_ir[INSTR_W-5 -: 4];
  assign w_rs     = r_ir[INSTR_W-9 -: 4];
  assign w_addr   = r_ir[ADDR_W-1:0];

  ctrl_decoder u_decoder (
    .i_opcode  (w_opcode),
    .o_cls     (w_cls_raw),
    .o_alu_op  (w_alu_op),
    .o_dmem_we (w_dec_we)
  );

  assign w_cls = op_class_e'(w_cls_raw);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Architectural registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc  <= RESET_PC;
      r_ir  <= '0;
`ifdef MULTICYCLE_CTRL_TRAP_EN
      r_epc <= '0;
`endif
    end else begin
      r_pc  <= w_pc_nxt;
      r_ir  <= w_ir_nxt;
`ifdef MULTICYCLE_CTRL_TRAP_EN
      r_epc <= w_epc_nxt;
`endif
    end
  end

  // Next-state and register updates
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    w_epc_nxt   = r_epc;
`endif
    case (r_state)
      StFetch: begin
        if (imem_ack) begin
          w_ir_nxt    = imem_rdata;
          w_pc_nxt    = r_pc + ADDR_W'(1);
          w_state_nxt = StDecode;
        end
      end
      StDecode: begin
        case (w_cls)
          ClsAlu:    w_state_nxt = StExec;
          ClsMem:    w_state_nxt = StMem;
          ClsBranch: begin
            w_state_nxt = StFetch;
            // JZ tests rd through read port A, which follows IR combinationally
            if (w_opcode == OpJmp || rf_rdata_a == '0) begin
              w_pc_nxt = w_addr;
            end
          end
          ClsHalt:   w_state_nxt = StHalt;
          default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
            w_state_nxt = StTrap;
`else
            w_state_nxt = StFetch;
`endif
          end
        endcase
      end
      StExec:  w_state_nxt = StFetch;
      StMem: begin
        if (dmem_ack) begin
          w_state_nxt = w_dec_we ? StFetch : StWb;
        end
      end
      StWb:    w_state_nxt = StFetch;
      StHalt:  w_state_nxt = StHalt;
      StTrap: begin
        // PC already points past the trapping instruction
`ifdef MULTICYCLE_CTRL_TRAP_EN
        w_epc_nxt = r_pc - ADDR_W'(1);
`endif
        w_pc_nxt    = TRAP_VEC;
        w_state_nxt = StFetch;
      end
      default: w_state_nxt = StFetch;
    endcase
  end

  // Outputs. Reset forces state to FETCH asynchronously, so gating strobes with
  // reset_n is what keeps imem_req low during reset.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = WbAlu;
    halted   = 1'b0;
    case (r_state)
      StFetch: imem_req = reset_n;
      StMem: begin
        dmem_req = reset_n;
        dmem_we  = reset_n & w_dec_we;
      end
      StExec:  rf_we = reset_n;
      StWb: begin
        rf_we  = reset_n;
        wb_sel = WbMem;
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr  = r_pc;
  assign dmem_addr  = w_addr;
  assign rf_raddr_a = w_rd;
  assign rf_raddr_b = w_rs;
  assign rf_waddr   = w_rd;
  assign alu_op     = w_alu_op;
  assign imm        = DATA_W'(w_addr);
`ifdef MULTICYCLE_CTRL_TRAP_EN
  assign epc        = r_epc;
`endif

endmodule
